// File: rtl/de2_115_web_qsys_irq_ctrl.sv
// rtl/de2_115_web_qsys_irq_ctrl.sv - interrupt controller with per-source edge/level mode
// Avalon-MM register slave aggregating N_IRQ sources into a single registered CPU irq.
module de2_115_web_qsys_irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_ACK     = 3'd5;
  localparam logic [2:0] ADDR_EVCOUNT = 3'd6;

  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] latch_q, latch_d;
  logic [N_IRQ-1:0] irq_d_q, irq_d_d;
  logic [15:0]      evcount_q, evcount_d;
  logic [15:0]      readdata_q, readdata_d;
  logic             irq_q, irq_out_d;

  logic             wr_stb;
  logic             wr_pending, wr_enable, wr_mode, wr_ack, wr_evcount;
  logic [N_IRQ-1:0] wdata;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] mode_fall;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] active;
  logic             any_active;
  logic [3:0]       vec_idx;
  logic             ev_hit;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[15:N_IRQ];
  assign wdata        = writedata[N_IRQ-1:0];

  always_comb begin
    wr_stb     = chipselect & ~write_n;
    wr_pending = wr_stb && (address == ADDR_PENDING);
    wr_enable  = wr_stb && (address == ADDR_ENABLE);
    wr_mode    = wr_stb && (address == ADDR_MODE);
    wr_ack     = wr_stb && (address == ADDR_ACK);
    wr_evcount = wr_stb && (address == ADDR_EVCOUNT);

    edge_det = irq_in & ~irq_d_q;

    // ACK indices at or above N_IRQ match no source and so fall away naturally
    clr = wr_pending ? wdata : '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (wr_ack && (writedata[3:0] == 4'(i))) begin
        clr[i] = 1'b1;
      end
    end

    enable_d  = wr_enable ? wdata : enable_q;
    mode_d    = wr_mode ? wdata : mode_q;
    mode_fall = mode_q & ~mode_d;

    // Set beats clear; a source leaving edge mode drops its latch outright
    latch_d = ((latch_q & ~clr) | (edge_det & mode_q)) & ~mode_fall;

    pending    = (latch_q & mode_q) | (irq_in & ~mode_q);
    active     = pending & enable_q;
    any_active = |active;

    vec_idx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vec_idx = 4'(i);
      end
    end

    ev_hit = |(edge_det & mode_q);
    if (wr_evcount) begin
      evcount_d = ev_hit ? 16'd1 : 16'd0;
    end else if (ev_hit && (evcount_q != 16'hFFFF)) begin
      evcount_d = evcount_q + 16'd1;
    end else begin
      evcount_d = evcount_q;
    end

    case (address)
      ADDR_PENDING: readdata_d = 16'(pending);
      ADDR_ENABLE:  readdata_d = 16'(enable_q);
      ADDR_MODE:    readdata_d = 16'(mode_q);
      ADDR_ACTIVE:  readdata_d = 16'(active);
      ADDR_VECTOR:  readdata_d = any_active ? {1'b1, 11'd0, vec_idx} : 16'h0000;
      ADDR_EVCOUNT: readdata_d = evcount_q;
      default:      readdata_d = 16'h0000;
    endcase

    irq_d_d   = irq_in;
    irq_out_d = any_active;
  end

  // irq_d resets to ones so a line already high at reset release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= '0;
      mode_q     <= '0;
      latch_q    <= '0;
      irq_d_q    <= '1;
      evcount_q  <= 16'h0000;
      readdata_q <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      latch_q    <= latch_d;
      irq_d_q    <= irq_d_d;
      evcount_q  <= evcount_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_out_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_de2_115_web_qsys_irq_ctrl.sv
// tb/tb_de2_115_web_qsys_irq_ctrl.sv - scoreboard bench for de2_115_web_qsys_irq_ctrl
module tb_de2_115_web_qsys_irq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   address = 3'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [15:0]  writedata = 16'h0000;
  logic [15:0]  readdata;
  logic [N-1:0] irq_in = '1;
  logic         irq;

  de2_115_web_qsys_irq_ctrl #(.N_IRQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t rd_e;
  exp_t irq_e;
  event irq_ev;

  int total = 0;
  int bad   = 0;

  logic rd_issue = 1'b0;
  logic rd_tag   = 1'b0;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endfunction

  always @(posedge clk) rd_tag <= rd_issue;

  always @(negedge clk) begin
    if (rd_tag) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_queue_underflow: got readdata 0x%04h expected no read", readdata);
      end else begin
        rd_e = rd_q.pop_front();
        check(rd_e.name, readdata, rd_e.val);
      end
    end
  end

  initial begin
    forever begin
      @(irq_ev);
      while (irq_q.size() > 0) begin
        irq_e = irq_q.pop_front();
        check(irq_e.name, {15'd0, irq}, irq_e.val);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] v, input string n);
    exp_t e;
    e.val  = v;
    e.name = n;
    rd_q.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_issue   = 1'b1;
    tick();
    rd_issue   = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input logic v, input string n);
    exp_t e;
    e.val  = {15'd0, v};
    e.name = n;
    irq_q.push_back(e);
    -> irq_ev;
    #0;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    irq_in = 8'hFF;
    reset  = 1'b1;
    tick();
    tick();
    chk_irq(1'b0, "reset_irq");
    reset = 1'b0;
    tick();

    rd(3'd1, 16'h0000, "reset_enable");
    rd(3'd2, 16'h0000, "reset_mode");
    rd(3'd0, 16'h00FF, "reset_pending_level_live");
    rd(3'd4, 16'h0000, "reset_vector_zero");
    wr(3'd2, 16'h00FF);
    rd(3'd0, 16'h0000, "reset_held_high_no_edge");
    rd(3'd6, 16'h0000, "reset_evcount");
    irq_in = 8'h00;
    wr(3'd2, 16'h0000);

    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    chk_irq(1'b0, "edge_irq_latency");
    tick();
    chk_irq(1'b1, "edge_irq_set");
    rd(3'd0, 16'h0001, "edge_pending");
    rd(3'd4, 16'h8000, "edge_vector");
    wr(3'd5, 16'h0000);
    chk_irq(1'b1, "ack_irq_latency");
    tick();
    chk_irq(1'b0, "ack_irq_clear");
    rd(3'd0, 16'h0000, "ack_pending");
    rd(3'd6, 16'h0001, "edge_evcount");

    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0004);
    irq_in = 8'h04;
    tick();
    chk_irq(1'b1, "level_irq_set");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0004, "level_pending_write_ignored");
    chk_irq(1'b1, "level_irq_hold");
    irq_in = 8'h00;
    tick();
    chk_irq(1'b0, "level_irq_drop");

    wr(3'd1, 16'h00FF);
    irq_in = 8'h28;
    rd(3'd4, 16'h8003, "prio_vector_3");
    rd(3'd3, 16'h0028, "prio_active");
    irq_in = 8'h20;
    rd(3'd4, 16'h8005, "prio_vector_5");
    irq_in = 8'h00;
    rd(3'd4, 16'h0000, "vector_idle");
    rd(3'd7, 16'h0000, "unmapped_read");
    rd(3'd5, 16'h0000, "ack_read_zero");

    wr(3'd2, 16'h0002);
    irq_in = 8'h02;
    wr(3'd0, 16'h0002);
    irq_in = 8'h00;
    rd(3'd0, 16'h0002, "set_wins");
    wr(3'd5, 16'h0009);
    rd(3'd0, 16'h0002, "ack_out_of_range");
    wr(3'd5, 16'h0001);
    rd(3'd0, 16'h0000, "ack_index_1");
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    wr(3'd2, 16'h0000);
    wr(3'd2, 16'h0002);
    rd(3'd0, 16'h0000, "mode_fall_clears_latch");
    rd(3'd6, 16'h0003, "evcount_running");

    wr(3'd6, 16'h0000);
    wr(3'd2, 16'h0003);
    irq_in = 8'h03;
    tick();
    irq_in = 8'h00;
    rd(3'd6, 16'h0001, "evcount_multi_edge");
    wr(3'd6, 16'h0000);
    for (int i = 0; i < 65535; i++) begin
      irq_in = ((i % 2) == 0) ? 8'h01 : 8'h02;
      tick();
    end
    rd(3'd6, 16'hFFFF, "evcount_preload");
    irq_in = 8'h02;
    tick();
    rd(3'd6, 16'hFFFF, "evcount_saturate");
    irq_in = 8'h01;
    wr(3'd6, 16'h0000);
    rd(3'd6, 16'h0001, "evcount_clear_plus_edge");

    chk_irq(1'b1, "pre_reset_irq");
    reset = 1'b1;
    #1;
    chk_irq(1'b0, "async_reset_irq");
    check("async_reset_readdata", readdata, 16'h0000);
    tick();
    tick();
    reset = 1'b0;
    tick();
    rd(3'd0, 16'h0001, "post_reset_level_live");
    wr(3'd2, 16'h0003);
    rd(3'd0, 16'h0000, "post_reset_no_latch");
    rd(3'd6, 16'h0000, "post_reset_evcount");
    rd(3'd1, 16'h0000, "post_reset_enable");
    chk_irq(1'b0, "post_reset_irq");
    tick();
    tick();

    if (rd_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL rd_queue_drain: got %0d pending reads expected 0", rd_q.size());
    end
    if (irq_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL irq_queue_drain: got %0d pending checks expected 0", irq_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
